// File: rtl/breakout_status_tracker_pkg.sv
// breakout_status_tracker_pkg: shared game-flow and tracker state encodings
package breakout_status_tracker_pkg;
    localparam logic [1:0] S_START = 2'b00;
    localparam logic [1:0] S_GAME  = 2'b01;
    localparam logic [1:0] S_END   = 2'b10;
    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_SERVE = 2'b01,
        T_PLAY  = 2'b10,
        T_DONE  = 2'b11
    } trk_state_e;
endpackage

// File: rtl/breakout_serve_timer.sv
// breakout_serve_timer: counts frame ticks during a serve and flags the final one
module breakout_serve_timer #(
    parameter int SERVE_FRAMES = 90
) (
    input  logic clk,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // next count: reload on serve start, advance on each enabled tick
    always_comb cnt_d = load_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
    // counter register with synchronous clear
    always_ff @(posedge clk)
        if (clr_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign done_o = en_i && (cnt_q == CW'(SERVE_FRAMES - 1));
endmodule

// File: rtl/breakout_status_tracker.sv
// breakout_status_tracker: score, lives, bricks and serve-pause tracking for breakout
module breakout_status_tracker
    import breakout_status_tracker_pkg::*;
#(
    parameter int NUM_BRICKS       = 40,
    parameter int START_LIVES      = 3,
    parameter int POINTS_PER_BRICK = 10,
    parameter int SCORE_W          = 16,
    parameter int SERVE_FRAMES     = 90
) (
    input  logic                              clk,
    input  logic                              reset_btn,
    input  logic                              game_reset,
    input  logic [1:0]                        state,
    input  logic                              frame_tick,
    input  logic                              brick_hit,
    input  logic                              ball_lost,
    output logic [SCORE_W-1:0]                score,
    output logic [2:0]                        lives,
    output logic [$clog2(NUM_BRICKS+1)-1:0]   bricks_left,
    output logic                              serve_hold,
    output logic                              serve_release,
    output logic                              game_over_signal,
    output logic                              game_won_signal
);
    localparam int BW = $clog2(NUM_BRICKS + 1);
    trk_state_e         st_q, st_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    logic [2:0]         lives_q, lives_d;
    logic [BW-1:0]      bricks_q, bricks_d;
    logic               release_q, release_d, over_q, over_d, won_q, won_d;
    logic               clear, load, tmr_en, tmr_done, win;
    assign clear = reset_btn || game_reset;
    assign sum   = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_BRICK);
    breakout_serve_timer #(.SERVE_FRAMES(SERVE_FRAMES)) u_timer (
        .clk    (clk),
        .clr_i  (clear),
        .load_i (load),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );
    // next state: serve timing, brick/ball events (brick first, a win drops the lost ball)
    always_comb begin
        st_d      = st_q;
        score_d   = score_q;
        lives_d   = lives_q;
        bricks_d  = bricks_q;
        release_d = 1'b0;
        won_d     = 1'b0;
        over_d    = over_q;
        load      = 1'b0;
        tmr_en    = 1'b0;
        win       = 1'b0;
        if (st_q == T_IDLE) begin
            if (state == S_GAME) begin
                st_d = T_SERVE;
                load = 1'b1;
            end
        end else if (state != S_GAME) begin
            st_d = T_DONE;
        end else if (st_q != T_DONE) begin
            if (brick_hit && bricks_q != '0) begin
                bricks_d = bricks_q - BW'(1);
                score_d  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                if (bricks_q == BW'(1)) begin
                    win   = 1'b1;
                    won_d = 1'b1;
                    st_d  = T_DONE;
                end
            end
            if (st_q == T_SERVE) begin
                tmr_en = frame_tick;
                if (tmr_done && !win) begin
                    release_d = 1'b1;
                    st_d      = T_PLAY;
                end
            end else if (ball_lost && !win) begin
                if (lives_q > 3'd1) begin
                    lives_d = lives_q - 3'd1;
                    st_d    = T_SERVE;
                    load    = 1'b1;
                end else begin
                    lives_d = 3'd0;
                    over_d  = 1'b1;
                    st_d    = T_DONE;
                end
            end
        end
    end
    // state and status registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            st_q      <= T_IDLE;
            score_q   <= '0;
            lives_q   <= 3'(START_LIVES);
            bricks_q  <= BW'(NUM_BRICKS);
            release_q <= 1'b0;
            over_q    <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            bricks_q  <= bricks_d;
            release_q <= release_d;
            over_q    <= over_d;
            won_q     <= won_d;
        end
    end
    assign score            = score_q;
    assign lives            = lives_q;
    assign bricks_left      = bricks_q;
    assign serve_hold       = st_q != T_PLAY;
    assign serve_release    = release_q;
    assign game_over_signal = over_q;
    assign game_won_signal  = won_q;
endmodule

// File: tb/tb_breakout_status_tracker.sv
// tb_breakout_status_tracker: directed checks of serve timing, scoring, lives and clears
module tb_breakout_status_tracker;
    logic        clk = 1'b0;
    logic        reset_btn, game_reset, frame_tick, brick_hit, ball_lost;
    logic [1:0]  state;
    logic [15:0] score;
    logic [3:0]  score_s;
    logic [2:0]  lives, lives_s;
    logic [2:0]  bricks_left;
    logic [5:0]  bricks_s;
    logic        serve_hold, serve_release, game_over_signal, game_won_signal;
    logic        hold_s, rel_s, over_s, won_s;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    breakout_status_tracker #(.NUM_BRICKS(4), .SCORE_W(16)) dut (
        .clk(clk), .reset_btn(reset_btn), .game_reset(game_reset), .state(state),
        .frame_tick(frame_tick), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .score(score), .lives(lives), .bricks_left(bricks_left),
        .serve_hold(serve_hold), .serve_release(serve_release),
        .game_over_signal(game_over_signal), .game_won_signal(game_won_signal)
    );

    breakout_status_tracker #(.SCORE_W(4)) dut_s (
        .clk(clk), .reset_btn(reset_btn), .game_reset(game_reset), .state(state),
        .frame_tick(frame_tick), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .score(score_s), .lives(lives_s), .bricks_left(bricks_s),
        .serve_hold(hold_s), .serve_release(rel_s),
        .game_over_signal(over_s), .game_won_signal(won_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int n);
        frame_tick = 1'b1;
        for (int i = 0; i < n; i++) tick();
        frame_tick = 1'b0;
    endtask

    task automatic hit();
        brick_hit = 1'b1;
        tick();
        brick_hit = 1'b0;
    endtask

    task automatic lose();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
    endtask

    task automatic do_reset();
        reset_btn = 1'b1;
        state = 2'b00;
        tick();
        reset_btn = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        check({tag, " score"}, score, 0);
        check({tag, " lives"}, lives, 3);
        check({tag, " bricks"}, bricks_left, 4);
        check({tag, " hold"}, serve_hold, 1);
        check({tag, " release"}, serve_release, 0);
        check({tag, " over"}, game_over_signal, 0);
        check({tag, " won"}, game_won_signal, 0);
    endtask

    initial begin
        reset_btn = 1'b1; game_reset = 1'b0; state = 2'b00;
        frame_tick = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
        tick(); tick();
        reset_btn = 1'b0;
        check_clear("reset");
        // serve pause: 89 ticks hold, 90th releases once
        state = 2'b01;
        tick();
        check("serve enter hold", serve_hold, 1);
        frame_tick = 1'b1;
        for (int i = 0; i < 89; i++) begin
            tick();
            check("serve early release", serve_release, 0);
        end
        check("serve 89 hold", serve_hold, 1);
        tick();
        frame_tick = 1'b0;
        check("serve 90 release", serve_release, 1);
        check("serve 90 hold", serve_hold, 0);
        tick();
        check("serve release pulse", serve_release, 0);
        // bricks, win pulse, saturation on the narrow instance
        for (int k = 1; k <= 4; k++) begin
            hit();
            check("hit score", score, 10 * k);
            check("hit bricks", bricks_left, 4 - k);
            check("sat score", score_s, (10 * k > 15) ? 15 : 10 * k);
            check("win pulse", game_won_signal, k == 4);
        end
        tick();
        check("win one cycle", game_won_signal, 0);
        check("win done hold", serve_hold, 1);
        hit();
        check("5th hit bricks", bricks_left, 0);
        check("5th hit score", score, 40);
        // lives: lost ball during serve ignored, then 3 losses
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        check_clear("game_reset");
        tick();
        lose();
        check("lost in serve", lives, 3);
        serve(90);
        for (int k = 1; k <= 3; k++) begin
            lose();
            check("lost lives", lives, 3 - k);
            check("lost over", game_over_signal, k == 3);
            check("lost hold", serve_hold, 1);
            if (k < 3) serve(90);
        end
        tick(); tick();
        check("over held", game_over_signal, 1);
        check("over lives", lives, 0);
        check("over no win", game_won_signal, 0);
        // simultaneous last brick and last ball
        do_reset();
        state = 2'b01;
        tick();
        serve(90);
        hit(); hit(); hit();
        lose(); serve(90);
        lose(); serve(90);
        check("pre-sim lives", lives, 1);
        check("pre-sim bricks", bricks_left, 1);
        brick_hit = 1'b1; ball_lost = 1'b1;
        tick();
        brick_hit = 1'b0; ball_lost = 1'b0;
        check("sim win", game_won_signal, 1);
        check("sim lives", lives, 1);
        check("sim over", game_over_signal, 0);
        check("sim bricks", bricks_left, 0);
        tick();
        check("sim over later", game_over_signal, 0);
        // game_reset mid-play
        do_reset();
        state = 2'b01;
        tick();
        serve(90);
        hit();
        check("midplay score", score, 10);
        check("midplay hold", serve_hold, 0);
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        check_clear("midplay clear");
        // state leaves GAME mid-serve: frozen in T_DONE
        do_reset();
        state = 2'b01;
        tick();
        serve(40);
        state = 2'b10;
        tick();
        state = 2'b01;
        frame_tick = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("done no release", serve_release, 0);
        end
        frame_tick = 1'b0;
        check("done hold", serve_hold, 1);
        hit();
        check("done bricks", bricks_left, 4);
        check("done score", score, 0);
        lose();
        check("done lives", lives, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
